// File: rtl/aes_block_serdes_if.sv
// rtl/aes_block_serdes_if.sv - byte-serial input and output handshakes around the AES block serdes
interface aes_block_serdes_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_is_key;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_data, in_valid, in_is_key, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_is_key, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/aes_block_serdes.sv
// rtl/aes_block_serdes.sv - byte-serial load, settle and ciphertext streaming around a combinational AES core
module aes_block_serdes #(
   parameter int unsigned  SETTLE_CYCLES = 2,
   parameter logic [127:0] KEY_RESET     = 128'h000102030405060708090a0b0c0d0e0f
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   aes_block_serdes_if.slave   bus,
   output logic [127:0]        blk_pt,
   output logic [127:0]        blk_key,
   input  logic [127:0]        blk_ct,
   output logic                busy,
   output logic [7:0]          blk_count
);

   // SETTLE_CYCLES is legal only in 0..15 so it fits the 4-bit settle counter
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SEND   = 2'd2
   } state_t;

   state_t       state, state_nx;
   logic [127:0] pt_reg, pt_nx;
   logic [127:0] key_reg, key_nx;
   logic [127:0] ct_reg, ct_nx;
   logic [3:0]   pt_cnt, pt_cnt_nx;
   logic [3:0]   key_cnt, key_cnt_nx;
   logic [3:0]   out_cnt, out_cnt_nx;
   logic [3:0]   settle_cnt, settle_cnt_nx;
   logic [7:0]   blk_count_nx;
   logic         in_hs;
   logic         out_hs;

   assign bus.in_ready  = ena & (state == ST_LOAD);
   assign bus.out_valid = ena & (state == ST_SEND);
   assign bus.out_data  = ct_reg[127:120];
   assign busy          = (state != ST_LOAD);
   assign blk_pt        = pt_reg;
   assign blk_key       = key_reg;

   assign in_hs  = bus.in_valid & bus.in_ready;
   assign out_hs = bus.out_valid & bus.out_ready;

   always_comb begin
      state_nx      = state;
      pt_nx         = pt_reg;
      key_nx        = key_reg;
      ct_nx         = ct_reg;
      pt_cnt_nx     = pt_cnt;
      key_cnt_nx    = key_cnt;
      out_cnt_nx    = out_cnt;
      settle_cnt_nx = settle_cnt;
      blk_count_nx  = blk_count;

      case (state)
         ST_LOAD: begin
            if (in_hs) begin
               if (bus.in_is_key) begin
                  // key bytes are independent of block progress; the counter just wraps
                  key_nx     = {key_reg[119:0], bus.in_data};
                  key_cnt_nx = key_cnt + 4'd1;
               end else begin
                  pt_nx = {pt_reg[119:0], bus.in_data};
                  if (pt_cnt == 4'd15) begin
                     pt_cnt_nx     = 4'd0;
                     settle_cnt_nx = SETTLE_INIT;
                     state_nx      = ST_SETTLE;
                  end else begin
                     pt_cnt_nx = pt_cnt + 4'd1;
                  end
               end
            end
         end

         ST_SETTLE: begin
            // gives the combinational core a fixed margin before the ciphertext is sampled
            if (settle_cnt == 4'd0) begin
               ct_nx      = blk_ct;
               out_cnt_nx = 4'd0;
               state_nx   = ST_SEND;
            end else begin
               settle_cnt_nx = settle_cnt - 4'd1;
            end
         end

         ST_SEND: begin
            if (out_hs) begin
               ct_nx      = {ct_reg[119:0], 8'h00};
               out_cnt_nx = out_cnt + 4'd1;
               if (out_cnt == 4'd15) begin
                  blk_count_nx = blk_count + 8'd1;
                  state_nx     = ST_LOAD;
               end
            end
         end

         default: begin
            state_nx = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_LOAD;
         pt_reg     <= '0;
         key_reg    <= KEY_RESET;
         ct_reg     <= '0;
         pt_cnt     <= '0;
         key_cnt    <= '0;
         out_cnt    <= '0;
         settle_cnt <= '0;
         blk_count  <= '0;
      end else if (ena) begin
         state      <= state_nx;
         pt_reg     <= pt_nx;
         key_reg    <= key_nx;
         ct_reg     <= ct_nx;
         pt_cnt     <= pt_cnt_nx;
         key_cnt    <= key_cnt_nx;
         out_cnt    <= out_cnt_nx;
         settle_cnt <= settle_cnt_nx;
         blk_count  <= blk_count_nx;
      end
   end

endmodule

// File: tb/tb_aes_block_serdes.sv
// tb/tb_aes_block_serdes.sv - directed and randomized checks of aes_block_serdes around a stand-in AES core
module tb_aes_block_serdes;

   localparam logic [127:0] KEY_RST = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT2     = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam int           BOUND   = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       sel = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_is_key = 1'b0;
   logic       out_ready = 1'b0;

   int ntests = 0;
   int nfail  = 0;

   logic [127:0] m_key [0:1];
   logic [127:0] m_pt  [0:1];
   logic [7:0]   m_cnt [0:1];

   always #5 clk = ~clk;

   // stand-in core: real AES answers for the two reference vectors, a keyed mix otherwise
   function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] key);
      if (pt == PT1 && key == KEY_RST) return CT1;
      if (pt == PT2 && key == KEY2) return CT2;
      return pt ^ {key[119:0], key[127:120]} ^ 128'hc36a_5f19_0e7d_b284_4c91_a3f0_6e2b_d758;
   endfunction

   aes_block_serdes_if ifa ();
   aes_block_serdes_if ifb ();

   logic [127:0] pt_a, key_a, ct_a, pt_b, key_b, ct_b;
   logic         busy_a, busy_b;
   logic [7:0]   cnt_a, cnt_b;

   assign ifa.in_data   = in_data;
   assign ifa.in_is_key = in_is_key;
   assign ifa.in_valid  = in_valid & ~sel;
   assign ifa.out_ready = out_ready & ~sel;
   assign ifb.in_data   = in_data;
   assign ifb.in_is_key = in_is_key;
   assign ifb.in_valid  = in_valid & sel;
   assign ifb.out_ready = out_ready & sel;
   assign ct_a = core_f(pt_a, key_a);
   assign ct_b = core_f(pt_b, key_b);

   aes_block_serdes #(.SETTLE_CYCLES(2), .KEY_RESET(KEY_RST)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifa.slave),
      .blk_pt(pt_a), .blk_key(key_a), .blk_ct(ct_a), .busy(busy_a), .blk_count(cnt_a)
   );

   aes_block_serdes #(.SETTLE_CYCLES(0), .KEY_RESET(KEY_RST)) dut_s0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifb.slave),
      .blk_pt(pt_b), .blk_key(key_b), .blk_ct(ct_b), .busy(busy_b), .blk_count(cnt_b)
   );

   logic         o_in_ready, o_out_valid, o_busy;
   logic [7:0]   o_out_data, o_cnt;
   logic [127:0] o_pt, o_key;

   assign o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
   assign o_out_valid = sel ? ifb.out_valid : ifa.out_valid;
   assign o_out_data  = sel ? ifb.out_data  : ifa.out_data;
   assign o_busy      = sel ? busy_b : busy_a;
   assign o_cnt       = sel ? cnt_b  : cnt_a;
   assign o_pt        = sel ? pt_b   : pt_a;
   assign o_key       = sel ? key_b  : key_a;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic k, output int waited);
      @(negedge clk);
      in_data   = b;
      in_is_key = k;
      in_valid  = 1'b1;
      waited    = 0;
      while (!o_in_ready && waited < BOUND) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_wait", 128'(waited < BOUND), 128'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_is_key = 1'b0;
   endtask

   task automatic send_key(input logic [127:0] key);
      int w;
      for (int i = 0; i < 16; i++) begin
         send_byte(key[127-8*i -: 8], 1'b1, w);
         m_key[sel] = {m_key[sel][119:0], key[127-8*i -: 8]};
      end
   endtask

   task automatic send_block(input logic [127:0] pt, input int first, input int last);
      int w;
      for (int i = first; i <= last; i++) begin
         send_byte(pt[127-8*i -: 8], 1'b0, w);
      end
   endtask

   task automatic wait_first_out(input int exp_lat, input logic junk);
      int k = 0;
      @(negedge clk);
      if (junk) begin
         in_valid = 1'b1;
         in_data  = 8'hee;
      end
      while (!o_out_valid && k < BOUND) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      check("settle_latency", 128'(k), 128'(exp_lat));
   endtask

   task automatic recv_block(input logic [127:0] exp_ct, input logic stall, input int stop_after);
      int         n = 0;
      int         cyc = 0;
      logic       held_v = 1'b0;
      logic [7:0] held = 8'h00;
      logic       rdy;
      while (n < stop_after && cyc < BOUND) begin
         @(negedge clk);
         if (held_v) check("held_byte", 128'(o_out_data), 128'(held));
         if (o_out_valid) check("in_ready_in_send", 128'(o_in_ready), 128'd0);
         rdy = !stall || (cyc % 4 == 0) || (cyc % 4 == 3);
         out_ready = rdy;
         if (o_out_valid && rdy) begin
            check($sformatf("ct_byte%0d", n), 128'(o_out_data), 128'(exp_ct[127-8*n -: 8]));
            n++;
            held_v = 1'b0;
         end else if (o_out_valid) begin
            held_v = 1'b1;
            held   = o_out_data;
         end
         cyc++;
      end
      check("out_bytes_count", 128'(n), 128'(stop_after));
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic finish_block(input logic [127:0] pt);
      m_pt[sel]  = pt;
      m_cnt[sel] = m_cnt[sel] + 8'd1;
      check("after_out_valid", 128'(o_out_valid), 128'd0);
      check("after_busy", 128'(o_busy), 128'd0);
      check("after_in_ready", 128'(o_in_ready), 128'd1);
      check("blk_count", 128'(o_cnt), 128'(m_cnt[sel]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_key[d] = KEY_RST;
         m_pt[d]  = '0;
         m_cnt[d] = 8'd0;
      end
   endtask

   initial begin
      logic [127:0] pt;
      int           w;

      // reset state
      repeat (2) @(posedge clk);
      do_reset();
      check("rst_in_ready", 128'(o_in_ready), 128'd1);
      check("rst_out_valid", 128'(o_out_valid), 128'd0);
      check("rst_busy", 128'(o_busy), 128'd0);
      check("rst_blk_count", 128'(o_cnt), 128'd0);
      check("rst_blk_key", o_key, KEY_RST);
      check("rst_blk_pt", o_pt, 128'd0);

      // 1: default key, FIPS-197 vector
      send_block(PT1, 0, 15);
      check("t1_blk_pt", o_pt, PT1);
      wait_first_out(3, 1'b0);
      recv_block(CT1, 1'b0, 16);
      finish_block(PT1);

      // 2: key load then second reference vector
      send_key(KEY2);
      check("t2_blk_key", o_key, m_key[0]);
      send_block(PT2, 0, 15);
      wait_first_out(3, 1'b0);
      recv_block(CT2, 1'b0, 16);
      finish_block(PT2);

      // 3: backpressure, with stray input bytes offered while busy
      send_block(PT2, 0, 15);
      wait_first_out(3, 1'b1);
      recv_block(core_f(PT2, m_key[0]), 1'b1, 16);
      finish_block(PT2);

      // 4: reset in the middle of SEND
      send_block(PT1, 0, 15);
      wait_first_out(3, 1'b0);
      recv_block(core_f(PT1, m_key[0]), 1'b0, 5);
      do_reset();
      check("t4_out_valid", 128'(o_out_valid), 128'd0);
      check("t4_in_ready", 128'(o_in_ready), 128'd1);
      check("t4_blk_count", 128'(o_cnt), 128'd0);
      check("t4_blk_key", o_key, KEY_RST);
      send_block(PT1, 0, 15);
      wait_first_out(3, 1'b0);
      recv_block(CT1, 1'b0, 16);
      finish_block(PT1);

      // 5: ena low for three cycles partway through a block
      send_block(PT1, 0, 6);
      @(negedge clk);
      ena      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'ha5;
      repeat (3) begin
         #1 check("t5_in_ready_gated", 128'(o_in_ready), 128'd0);
         @(posedge clk);
         @(negedge clk);
      end
      ena      = 1'b1;
      in_valid = 1'b0;
      check("t5_partial_pt", o_pt, {m_pt[0][71:0], PT1[127:72]});
      send_block(PT1, 7, 15);
      wait_first_out(3, 1'b0);
      recv_block(CT1, 1'b0, 16);
      finish_block(PT1);

      // 6: zero-settle build, 256 back-to-back random blocks
      @(negedge clk);
      sel = 1'b1;
      for (int b = 0; b < 256; b++) begin
         if (b % 64 == 63) send_key({$urandom, $urandom, $urandom, $urandom});
         pt = {$urandom, $urandom, $urandom, $urandom};
         send_byte(pt[127:120], 1'b0, w);
         if (b > 0 && b % 64 != 63) check("t6_back_to_back", 128'(w), 128'd0);
         send_block(pt, 1, 15);
         wait_first_out(1, 1'b0);
         recv_block(core_f(pt, m_key[1]), 1'b0, 16);
         finish_block(pt);
      end
      check("t6_wrap", 128'(o_cnt), 128'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
